// File: rtl/cosine_iter_ctrl.sv
// cosine_iter_ctrl: sequential CORDIC cosine, IEEE-754 single angle in, Q1.31 cosine out
module cosine_iter_ctrl #(
  parameter int N_ITER = 32,
  parameter int IW     = 34
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CONV, ITER, DONE} state_t;
  localparam logic signed [IW-1:0] K_Q30   = IW'(32'sh26DD3B6A);
  localparam logic signed [IW-1:0] ONE_Q30 = IW'(32'sh40000000);
  // atan(2^-i) in Q2.30, rounded to nearest; the series is summed at 2^-62 so only the final rounding matters.
  // The -1 before rounding pushes exact-half cases down, since the dropped series tail is always negative there.
  function automatic logic [31:0] atan_q30(input int i);
    longint acc;
    int s;
    acc = 0;
    for (int k = 0; k < 32; k++) begin
      s = i * (2 * k + 1);
      if (s <= 62) acc += ((k % 2) != 0 ? -64'sd1 : 64'sd1) * ((64'sd1 <<< (62 - s)) / longint'(2 * k + 1));
    end
    return (i == 0) ? 32'h3243F6A9 : 32'((acc - 64'sd1 + (64'sd1 <<< 31)) >>> 32);
  endfunction
  logic signed [IW-1:0] atan_lut [32];
  for (genvar g = 0; g < 32; g++) begin : g_lut
    assign atan_lut[g] = IW'(atan_q30(g));
  end
  state_t               state_q, state_d;
  logic [31:0]          theta_q, theta_d, result_q, result_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]           i_q, i_d;
  logic                 done_q, done_d;
  logic [7:0]           exp_w;
  logic [IW-1:0]        man, mag;
  logic signed [IW-1:0] z_conv, xs, ys;
  logic                 pos;
  logic [31:0]          sat;
  assign exp_w  = theta_q[30:23];
  assign man    = IW'({1'b1, theta_q[22:0]});
  assign mag    = exp_w > 8'd127 ? ONE_Q30 :
                  exp_w < 8'd97  ? '0 :
                  exp_w >= 8'd120 ? man << (exp_w - 8'd120) : man >> (8'd120 - exp_w);
  assign z_conv = theta_q[31] ? -mag : mag;
  assign xs     = x_q >>> i_q;
  assign ys     = y_q >>> i_q;
  assign pos    = ~z_q[IW-1];
  assign sat    = x_q >= ONE_Q30 ? 32'h7FFFFFFF : {x_q[30:0], 1'b0};
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign result = result_q;
  // Next-state and datapath: capture, convert, rotate, then publish the saturated x.
  always_comb begin
    state_d  = state_q;
    theta_d  = theta_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    i_d      = i_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        theta_d = dataa;
        state_d = CONV;
      end
      CONV: begin
        x_d     = K_Q30;
        y_d     = '0;
        z_d     = z_conv;
        i_d     = '0;
        state_d = ITER;
      end
      ITER: begin
        x_d     = pos ? x_q - ys : x_q + ys;
        y_d     = pos ? y_q + xs : y_q - xs;
        z_d     = pos ? z_q - atan_lut[i_q] : z_q + atan_lut[i_q];
        i_d     = i_q + 5'd1;
        state_d = i_q == 5'(N_ITER - 1) ? DONE : ITER;
      end
      default: begin
        result_d = sat;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end
  // State register; every register freezes while clk_en is low, which also stretches done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      theta_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      theta_q  <= theta_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      i_q      <= i_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_cosine_iter_ctrl.sv
// tb_cosine_iter_ctrl: vector table, random angles against a real-valued cosine model, and control corner cases
module tb_cosine_iter_ctrl;
  localparam int N   = 32;
  localparam int TOL = 128;
  logic        clk = 1'b0, reset_n = 1'b0, clk_en = 1'b1, start = 1'b0;
  logic [31:0] dataa = '0;
  logic        busy, done;
  logic [31:0] result;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  cosine_iter_ctrl #(.N_ITER(N), .IW(34)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start),
    .dataa(dataa), .busy(busy), .done(done), .result(result)
  );
  typedef struct { logic [31:0] th; logic [31:0] exp; } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    total++;
    if ((act > exp ? act - exp : exp - act) > tol) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (tol %0d)", name, act, exp, tol);
    end
  endtask
  // Cosine of the angle the float encodes, with zero/clamp handling, scaled to Q1.31 and saturated.
  function automatic logic [31:0] model(input logic [31:0] th);
    int  e;
    real a, c;
    e = int'(th[30:23]);
    a = e > 127 ? 1.0 : e < 97 ? 0.0 : real'({1'b1, th[22:0]}) * (2.0 ** real'(e - 150));
    if (th[31]) a = -a;
    c = $cos(a) * 2147483648.0;
    return c >= 2147483647.0 ? 32'h7FFFFFFF : 32'($rtoi(c + 0.5));
  endfunction
  task automatic run_op(input logic [31:0] th, output logic [31:0] res, output int lat);
    @(negedge clk);
    dataa = th;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataa = $urandom;
    chk("busy_after_accept", busy, 1, 0);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    @(negedge clk);
    chk("done_pulse_width", done, 0, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] res, th;
    int          lat, cyc, last, pulses, n, e;
    logic        seen;
    tbl[0]  = '{32'h3F800000, 32'h4528A03D};
    tbl[1]  = '{32'hBF800000, 32'h4528A03D};
    tbl[2]  = '{32'h3F000000, 32'h7054A01A};
    tbl[3]  = '{32'hBF000000, 32'h7054A01A};
    tbl[4]  = '{32'h00000000, 32'h7FFFFFFF};
    tbl[5]  = '{32'h30800000, 32'h7FFFFFFF};
    tbl[6]  = '{32'h40000000, 32'h4528A03D};
    tbl[7]  = '{32'hC0000000, 32'h4528A03D};
    tbl[8]  = '{32'h7F800000, 32'h4528A03D};
    tbl[9]  = '{32'h7FC00000, 32'h4528A03D};
    tbl[10] = '{32'h80000001, 32'h7FFFFFFF};
    tbl[11] = '{32'h30000000, 32'h7FFFFFFF};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0, 0);
    chk("rst_done", done, 0, 0);
    chk("rst_result", result, 0, 0);
    reset_n = 1'b1;
    foreach (tbl[k]) begin
      run_op(tbl[k].th, res, lat);
      chk($sformatf("vec%0d_result", k), res, tbl[k].exp, TOL);
      chk($sformatf("vec%0d_latency", k), lat, N + 2, 0);
    end
    for (int r = 0; r < 24; r++) begin
      e = r < 12 ? int'($urandom_range(97, 126)) : int'($urandom_range(0, 254));
      if (r >= 12 && e >= 127) e++;
      th = {1'($urandom), 8'(e), 23'($urandom)};
      run_op(th, res, lat);
      chk($sformatf("rand%0d_%08h", r, th), res, model(th), TOL);
    end
    @(negedge clk);
    dataa = 32'h3F000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0, 0);
    chk("abort_done", done, 0, 0);
    chk("abort_result", result, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen |= done;
    end
    chk("abort_no_done", seen, 0, 0);
    start = 1'b1;
    cyc = 0;
    last = -1;
    pulses = 0;
    while (pulses < 3 && cyc < 500) begin
      dataa = busy ? $urandom : 32'h3F800000;
      @(negedge clk);
      cyc++;
      if (done) begin
        chk("b2b_result", result, 32'h4528A03D, TOL);
        if (last >= 0) chk("b2b_period", cyc - last, N + 3, 0);
        last = cyc;
        pulses++;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", pulses, 3, 0);
    repeat (N + 5) @(negedge clk);
    dataa = 32'h3F800000;
    start = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (!done && cyc < 1000) begin
      clk_en = 1'($urandom_range(0, 1));
      n += int'(clk_en);
      @(negedge clk);
      cyc++;
    end
    chk("clken_enabled_edges", n, N + 2, 0);
    chk("clken_result", result, 32'h4528A03D, TOL);
    clk_en = 1'b0;
    @(negedge clk);
    chk("clken_done_stretch", done, 1, 0);
    clk_en = 1'b1;
    @(negedge clk);
    chk("clken_done_release", done, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
